// File: rtl/bp_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// bp_cache_req_arbiter
//
// Shares a single LCE cache-service request channel between the I$ and D$
// request ports. One miss/uncached transaction is granted at a time, with
// round-robin priority between the two caches. The owner's request and
// metadata are forwarded to the LCE, req_complete is steered back to the
// owning cache, and the current/last owner is exposed so the tile can steer
// fill packets.
//
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   icache_req_*                      I$ request, metadata, ready, complete
//   dcache_req_*                      D$ request, metadata, ready, complete
//   req_o / req_v_o / req_ready_i     request channel to the LCE
//   req_metadata_o / req_metadata_v_o metadata channel to the LCE
//   req_complete_i                    LCE transaction-done pulse
//   owner_o                           0 = I$, 1 = D$ (current or last owner)
//   busy_o                            a transaction is granted, not complete
//
// Handshake semantics: a transfer happens in the cycle where valid and ready
// are both high. Once req_v_o is raised it stays on the same requester until
// the transfer happens (the selection is locked), so the payload seen by the
// LCE never switches under a stalled valid. Readies are combinational from
// req_ready_i and are only given to the selected requester while idle.
// -----------------------------------------------------------------------------
module bp_cache_req_arbiter #(
   parameter int req_width_p          = 128,
   parameter int req_metadata_width_p = 8
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,

   input  logic [req_width_p-1:0]          icache_req_i,
   input  logic                            icache_req_v_i,
   output logic                            icache_req_ready_o,
   input  logic [req_metadata_width_p-1:0] icache_req_metadata_i,
   input  logic                            icache_req_metadata_v_i,
   output logic                            icache_req_complete_o,

   input  logic [req_width_p-1:0]          dcache_req_i,
   input  logic                            dcache_req_v_i,
   output logic                            dcache_req_ready_o,
   input  logic [req_metadata_width_p-1:0] dcache_req_metadata_i,
   input  logic                            dcache_req_metadata_v_i,
   output logic                            dcache_req_complete_o,

   output logic [req_width_p-1:0]          req_o,
   output logic                            req_v_o,
   input  logic                            req_ready_i,
   output logic [req_metadata_width_p-1:0] req_metadata_o,
   output logic                            req_metadata_v_o,
   input  logic                            req_complete_i,

   output logic                            owner_o,
   output logic                            busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      META = 2'd1,
      BUSY = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   prio_q, prio_d;          // 1 = D$ wins a tie
   logic   lock_v_q, lock_v_d;      // selection frozen until handshake
   logic   lock_sel_q, lock_sel_d;
   logic   owner_q, owner_d;

   logic   idle;
   logic   sel;                     // selected requester in IDLE, 1 = D$
   logic   sel_v;
   logic   hs;
   logic   meta_owner;              // whose metadata is forwarded
   logic   owner_mv;
   logic   done;

   // ---------------------------------------------------------------------
   // Selection, request path and output steering
   // ---------------------------------------------------------------------
   always_comb begin
      idle = (state_q == IDLE);

      if (lock_v_q) begin
         sel = lock_sel_q;
      end else if (icache_req_v_i && dcache_req_v_i) begin
         sel = prio_q;
      end else begin
         sel = dcache_req_v_i;
      end

      sel_v = sel ? dcache_req_v_i : icache_req_v_i;

      // Outputs are qualified with reset_n_i so they read 0 as soon as reset
      // asserts, even though the request inputs may still be high.
      req_v_o            = reset_n_i & idle & sel_v;
      req_o              = sel ? dcache_req_i : icache_req_i;
      icache_req_ready_o = reset_n_i & idle & ~sel & req_ready_i;
      dcache_req_ready_o = reset_n_i & idle &  sel & req_ready_i;
      hs                 = req_v_o & req_ready_i;

      // In the handshake cycle the owner is not registered yet, so the live
      // selection steers metadata; afterwards the registered owner does.
      meta_owner       = idle ? sel : owner_q;
      owner_mv         = meta_owner ? dcache_req_metadata_v_i : icache_req_metadata_v_i;
      req_metadata_o   = meta_owner ? dcache_req_metadata_i : icache_req_metadata_i;
      req_metadata_v_o = reset_n_i & ((state_q == META) | hs) & owner_mv;

      done                  = reset_n_i & ~idle & req_complete_i;
      icache_req_complete_o = done & ~owner_q;
      dcache_req_complete_o = done &  owner_q;

      owner_o = owner_q;
      busy_o  = ~idle;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      lock_v_d   = lock_v_q;
      lock_sel_d = lock_sel_q;
      owner_d    = owner_q;

      case (state_q)
         IDLE: begin
            if (hs) begin
               owner_d  = sel;
               prio_d   = ~sel;
               lock_v_d = 1'b0;
               state_d  = owner_mv ? BUSY : META;
            end else if (req_v_o) begin
               lock_v_d   = 1'b1;
               lock_sel_d = sel;
            end else begin
               // Requester withdrew its valid: nothing left to hold.
               lock_v_d = 1'b0;
            end
         end
         META: begin
            // Completion wins over late metadata: the transaction is over.
            if (req_complete_i) begin
               state_d = IDLE;
            end else if (owner_mv) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (req_complete_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         prio_q     <= 1'b1;
         lock_v_q   <= 1'b0;
         lock_sel_q <= 1'b0;
         owner_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         lock_v_q   <= lock_v_d;
         lock_sel_q <= lock_sel_d;
         owner_q    <= owner_d;
      end
   end

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_cache_req_arbiter
//
// Directed scenarios for bp_cache_req_arbiter. Each granted request is
// predicted by pushing {icache_ready, dcache_ready, payload} into exp_q when
// the stimulus is driven; a monitor pops and compares on every LCE handshake.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_bp_cache_req_arbiter;

   localparam int W = 128;
   localparam int M = 8;

   logic          clk = 1'b0;
   logic          reset_n_i;

   logic [W-1:0]  icache_req_i;
   logic          icache_req_v_i;
   logic          icache_req_ready_o;
   logic [M-1:0]  icache_req_metadata_i;
   logic          icache_req_metadata_v_i;
   logic          icache_req_complete_o;

   logic [W-1:0]  dcache_req_i;
   logic          dcache_req_v_i;
   logic          dcache_req_ready_o;
   logic [M-1:0]  dcache_req_metadata_i;
   logic          dcache_req_metadata_v_i;
   logic          dcache_req_complete_o;

   logic [W-1:0]  req_o;
   logic          req_v_o;
   logic          req_ready_i;
   logic [M-1:0]  req_metadata_o;
   logic          req_metadata_v_o;
   logic          req_complete_i;
   logic          owner_o;
   logic          busy_o;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W+1:0]  exp_q[$];

   bp_cache_req_arbiter #(
      .req_width_p          (W),
      .req_metadata_width_p (M)
   ) dut (
      .clk_i                   (clk),
      .reset_n_i               (reset_n_i),
      .icache_req_i            (icache_req_i),
      .icache_req_v_i          (icache_req_v_i),
      .icache_req_ready_o      (icache_req_ready_o),
      .icache_req_metadata_i   (icache_req_metadata_i),
      .icache_req_metadata_v_i (icache_req_metadata_v_i),
      .icache_req_complete_o   (icache_req_complete_o),
      .dcache_req_i            (dcache_req_i),
      .dcache_req_v_i          (dcache_req_v_i),
      .dcache_req_ready_o      (dcache_req_ready_o),
      .dcache_req_metadata_i   (dcache_req_metadata_i),
      .dcache_req_metadata_v_i (dcache_req_metadata_v_i),
      .dcache_req_complete_o   (dcache_req_complete_o),
      .req_o                   (req_o),
      .req_v_o                 (req_v_o),
      .req_ready_i             (req_ready_i),
      .req_metadata_o          (req_metadata_o),
      .req_metadata_v_o        (req_metadata_v_o),
      .req_complete_i          (req_complete_i),
      .owner_o                 (owner_o),
      .busy_o                  (busy_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- stimulus helpers ----------------
   function automatic logic [W-1:0] rand_payload();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic void push_exp(input logic owner, input logic [W-1:0] p);
      exp_q.push_back({~owner, owner, p});
   endfunction

   task automatic clear_inputs();
      icache_req_i            = '0;
      icache_req_v_i          = 1'b0;
      icache_req_metadata_i   = '0;
      icache_req_metadata_v_i = 1'b0;
      dcache_req_i            = '0;
      dcache_req_v_i          = 1'b0;
      dcache_req_metadata_i   = '0;
      dcache_req_metadata_v_i = 1'b0;
      req_ready_i             = 1'b0;
      req_complete_i          = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset_n_i = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W+1:0] exp_v;
      if (reset_n_i && req_v_o && req_ready_i) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL grant_unexpected: got rdy_i/d=%b%b req=%h, want no grant",
                     icache_req_ready_o, dcache_req_ready_o, req_o);
         end else begin
            exp_v = exp_q.pop_front();
            if ({icache_req_ready_o, dcache_req_ready_o, req_o} !== exp_v) begin
               n_err++;
               $display("FAIL grant: got rdy_i/d=%b%b req=%h, want rdy_i/d=%b%b req=%h",
                        icache_req_ready_o, dcache_req_ready_o, req_o,
                        exp_v[W+1], exp_v[W], exp_v[W-1:0]);
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n_i = 1'b0;
      icache_req_v_i = 1'b1; dcache_req_v_i = 1'b1;
      icache_req_metadata_v_i = 1'b1; dcache_req_metadata_v_i = 1'b1;
      req_ready_i = 1'b1; req_complete_i = 1'b1;
      #3;
      n_cmp++;
      if ({req_v_o, icache_req_ready_o, dcache_req_ready_o, req_metadata_v_o,
           icache_req_complete_o, dcache_req_complete_o, busy_o, owner_o} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: got %b, want 00000000",
                  {req_v_o, icache_req_ready_o, dcache_req_ready_o, req_metadata_v_o,
                   icache_req_complete_o, dcache_req_complete_o, busy_o, owner_o});
      end
      apply_reset();
      @(negedge clk);
      n_cmp++;
      if ({busy_o, owner_o, req_v_o} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_release_idle: got busy/owner/v=%b, want 000",
                  {busy_o, owner_o, req_v_o});
      end
   endtask

   task automatic test_single();
      logic [W-1:0] pd;
      logic [M-1:0] md;
      pd = rand_payload();
      md = M'($urandom_range(0, 255));
      apply_reset();
      step();
      dcache_req_i = pd; dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
      push_exp(1'b1, pd);
      @(negedge clk);
      n_cmp++;
      if ({req_v_o, icache_req_ready_o, dcache_req_ready_o} !== 3'b101) begin
         n_err++;
         $display("FAIL single_hs: got v/rdy_i/rdy_d=%b, want 101",
                  {req_v_o, icache_req_ready_o, dcache_req_ready_o});
      end
      step();
      dcache_req_v_i = 1'b0; dcache_req_metadata_v_i = 1'b1; dcache_req_metadata_i = md;
      @(negedge clk);
      n_cmp++;
      if ({owner_o, busy_o, req_metadata_v_o, req_metadata_o} !== {3'b111, md}) begin
         n_err++;
         $display("FAIL single_meta: got own/busy/mv=%b meta=%h, want 111 meta=%h",
                  {owner_o, busy_o, req_metadata_v_o}, req_metadata_o, md);
      end
      step();
      dcache_req_metadata_v_i = 1'b0;
      repeat (5) step();
      @(negedge clk);
      n_cmp++;
      if ({busy_o, req_metadata_v_o} !== 2'b10) begin
         n_err++;
         $display("FAIL single_wait: got busy/mv=%b, want 10", {busy_o, req_metadata_v_o});
      end
      step();
      req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({icache_req_complete_o, dcache_req_complete_o} !== 2'b01) begin
         n_err++;
         $display("FAIL single_complete: got cmp_i/d=%b, want 01",
                  {icache_req_complete_o, dcache_req_complete_o});
      end
      step();
      req_complete_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy_o, owner_o} !== 2'b01) begin
         n_err++;
         $display("FAIL single_after: got busy/owner=%b, want 01", {busy_o, owner_o});
      end
   endtask

   task automatic test_both();
      logic [W-1:0] pi, pd;
      pi = rand_payload();
      pd = rand_payload();
      apply_reset();
      step();
      icache_req_i = pi; dcache_req_i = pd;
      icache_req_v_i = 1'b1; dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
      push_exp(1'b1, pd);
      push_exp(1'b0, pi);
      @(negedge clk);
      n_cmp++;
      if ({icache_req_ready_o, dcache_req_ready_o} !== 2'b01) begin
         n_err++;
         $display("FAIL both_first: got rdy_i/d=%b, want 01",
                  {icache_req_ready_o, dcache_req_ready_o});
      end
      step();
      dcache_req_v_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({req_v_o, icache_req_ready_o, dcache_req_ready_o} !== 3'b000) begin
         n_err++;
         $display("FAIL both_blocked: got v/rdy_i/rdy_d=%b, want 000",
                  {req_v_o, icache_req_ready_o, dcache_req_ready_o});
      end
      step();
      dcache_req_metadata_v_i = 1'b1;
      step();
      dcache_req_metadata_v_i = 1'b0;
      step();
      req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({dcache_req_complete_o, icache_req_ready_o} !== 2'b10) begin
         n_err++;
         $display("FAIL both_d_complete: got cmp_d/rdy_i=%b, want 10",
                  {dcache_req_complete_o, icache_req_ready_o});
      end
      step();
      req_complete_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({req_v_o, icache_req_ready_o} !== 2'b11) begin
         n_err++;
         $display("FAIL both_i_next: got v/rdy_i=%b, want 11", {req_v_o, icache_req_ready_o});
      end
      step();
      icache_req_v_i = 1'b0; icache_req_metadata_v_i = 1'b1;
      step();
      icache_req_metadata_v_i = 1'b0; req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({icache_req_complete_o, dcache_req_complete_o} !== 2'b10) begin
         n_err++;
         $display("FAIL both_i_complete: got cmp_i/d=%b, want 10",
                  {icache_req_complete_o, dcache_req_complete_o});
      end
      step();
      req_complete_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pi, pd;
      logic         got;
      pi = rand_payload();
      pd = rand_payload();
      apply_reset();
      step();
      icache_req_i = pi; dcache_req_i = pd;
      icache_req_v_i = 1'b1; dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) push_exp(k % 2 == 0, (k % 2 == 0) ? pd : pi);
      for (int k = 0; k < 6; k++) begin
         got = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_v_o && req_ready_i) begin
               got = 1'b1;
               break;
            end
         end
         n_cmp++;
         if (!got) begin
            n_err++;
            $display("FAIL rr_timeout: txn %0d got no handshake, want one within 10 cycles", k);
         end
         step();
         icache_req_metadata_v_i = 1'b1; dcache_req_metadata_v_i = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (owner_o !== (k % 2 == 0)) begin
            n_err++;
            $display("FAIL rr_owner: txn %0d got owner=%b, want %b", k, owner_o, (k % 2 == 0));
         end
         step();
         icache_req_metadata_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
         req_complete_i = 1'b1;
         if (k == 5) begin
            icache_req_v_i = 1'b0; dcache_req_v_i = 1'b0;
         end
         step();
         req_complete_i = 1'b0;
      end
   endtask

   task automatic test_lock();
      logic [W-1:0] pi, pd;
      pi = rand_payload();
      pd = rand_payload();
      apply_reset();
      step();
      icache_req_i = pi; icache_req_v_i = 1'b1; req_ready_i = 1'b0;
      step();
      dcache_req_i = pd; dcache_req_v_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({req_v_o, icache_req_ready_o, dcache_req_ready_o, req_o} !== {3'b100, pi}) begin
            n_err++;
            $display("FAIL lock_hold: cycle %0d got v/rdy=%b req=%h, want 100 req=%h",
                     k, {req_v_o, icache_req_ready_o, dcache_req_ready_o}, req_o, pi);
         end
         step();
      end
      req_ready_i = 1'b1;
      push_exp(1'b0, pi);
      push_exp(1'b1, pd);
      @(negedge clk);
      n_cmp++;
      if ({icache_req_ready_o, dcache_req_ready_o} !== 2'b10) begin
         n_err++;
         $display("FAIL lock_grant: got rdy_i/d=%b, want 10",
                  {icache_req_ready_o, dcache_req_ready_o});
      end
      step();
      icache_req_v_i = 1'b0; icache_req_metadata_v_i = 1'b1;
      step();
      icache_req_metadata_v_i = 1'b0; req_complete_i = 1'b1;
      step();
      req_complete_i = 1'b0;
      @(negedge clk);
      step();
      // D$ now owns in META; completing here abandons its metadata.
      dcache_req_v_i = 1'b0; req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({dcache_req_complete_o, req_metadata_v_o} !== 2'b10) begin
         n_err++;
         $display("FAIL lock_meta_complete: got cmp_d/mv=%b, want 10",
                  {dcache_req_complete_o, req_metadata_v_o});
      end
      step();
      req_complete_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL lock_idle: got busy=%b, want 0", busy_o);
      end
   endtask

   task automatic test_meta_hs();
      logic [W-1:0] pd;
      logic [M-1:0] md, mi;
      pd = rand_payload();
      md = M'($urandom_range(0, 255));
      mi = ~md;
      apply_reset();
      step();
      dcache_req_i = pd; dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
      dcache_req_metadata_i = md; dcache_req_metadata_v_i = 1'b1;
      push_exp(1'b1, pd);
      @(negedge clk);
      n_cmp++;
      if ({req_metadata_v_o, req_metadata_o} !== {1'b1, md}) begin
         n_err++;
         $display("FAIL meta_in_hs: got mv=%b meta=%h, want mv=1 meta=%h",
                  req_metadata_v_o, req_metadata_o, md);
      end
      step();
      dcache_req_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
      icache_req_metadata_i = mi; icache_req_metadata_v_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_metadata_v_o !== 1'b0) begin
         n_err++;
         $display("FAIL meta_non_owner: got mv=%b, want 0", req_metadata_v_o);
      end
      step();
      icache_req_metadata_v_i = 1'b0; dcache_req_metadata_v_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy_o, req_metadata_v_o} !== 2'b10) begin
         n_err++;
         $display("FAIL meta_busy: got busy/mv=%b, want 10", {busy_o, req_metadata_v_o});
      end
      step();
      dcache_req_metadata_v_i = 1'b0; req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dcache_req_complete_o !== 1'b1) begin
         n_err++;
         $display("FAIL meta_complete: got cmp_d=%b, want 1", dcache_req_complete_o);
      end
      step();
      req_complete_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] pi, pd;
      logic         got;
      pi = rand_payload();
      pd = rand_payload();
      apply_reset();
      step();
      dcache_req_i = pd; dcache_req_v_i = 1'b1; dcache_req_metadata_v_i = 1'b1;
      req_ready_i = 1'b1;
      push_exp(1'b1, pd);
      step();
      dcache_req_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
      icache_req_i = pi; icache_req_v_i = 1'b1;
      step();
      #3 reset_n_i = 1'b0;
      req_complete_i = 1'b1;
      #1;
      n_cmp++;
      if ({req_v_o, icache_req_ready_o, dcache_req_ready_o, req_metadata_v_o,
           icache_req_complete_o, dcache_req_complete_o, busy_o, owner_o} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %b, want 00000000",
                  {req_v_o, icache_req_ready_o, dcache_req_ready_o, req_metadata_v_o,
                   icache_req_complete_o, dcache_req_complete_o, busy_o, owner_o});
      end
      push_exp(1'b0, pi);
      step();
      reset_n_i = 1'b1; req_complete_i = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (req_v_o && req_ready_i) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL reset_mid_regrant: got no handshake, want one within 10 cycles");
      end
      step();
      icache_req_v_i = 1'b0; icache_req_metadata_v_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({owner_o, busy_o} !== 2'b01) begin
         n_err++;
         $display("FAIL reset_mid_owner: got owner/busy=%b, want 01", {owner_o, busy_o});
      end
      step();
      icache_req_metadata_v_i = 1'b0; req_complete_i = 1'b1;
      step();
      req_complete_i = 1'b0;
      repeat (3) step();
      req_complete_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({icache_req_complete_o, dcache_req_complete_o, busy_o} !== 3'b000) begin
         n_err++;
         $display("FAIL idle_complete: got cmp_i/cmp_d/busy=%b, want 000",
                  {icache_req_complete_o, dcache_req_complete_o, busy_o});
      end
      step();
      req_complete_i = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clear_inputs();
      reset_n_i = 1'b0;
      test_reset();
      test_single();
      test_both();
      test_back_to_back();
      test_lock();
      test_meta_hs();
      test_reset_mid();
      repeat (2) step();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_grants: got %0d expected grants never seen, want 0",
                  exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/bp_cache_req_arbiter.md
# bp_cache_req_arbiter

Shares one LCE cache-service request channel between the core's I$ and D$ request ports, so a minimal tile needs only one LCE. It grants one miss/uncached transaction at a time, round-robin, and forwards the owner's request and metadata to the LCE. It steers `req_complete` back to the owning cache and exposes the current owner so the tile can steer fill packets (data/tag/stat mem pkts).

## Interface
Parameters:
- `req_width_p`, 128: width of the packed cache request struct (I$ and D$ identical).
- `req_metadata_width_p`, 8: width of the packed request metadata struct.

Ports:
- `clk_i` in 1: single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `icache_req_i` in `req_width_p`: I$ request payload.
- `icache_req_v_i` in 1: I$ request valid.
- `icache_req_ready_o` out 1: I$ request accepted this cycle when high with valid.
- `icache_req_metadata_i` in `req_metadata_width_p`: I$ metadata.
- `icache_req_metadata_v_i` in 1: I$ metadata valid.
- `icache_req_complete_o` out 1: I$ transaction done pulse.
- `dcache_req_i`, `dcache_req_v_i`, `dcache_req_ready_o`, `dcache_req_metadata_i`, `dcache_req_metadata_v_i`, `dcache_req_complete_o`: same as the I$ ports, for D$.
- `req_o` out `req_width_p`: request to LCE.
- `req_v_o` out 1: request valid to LCE.
- `req_ready_i` in 1: LCE ready.
- `req_metadata_o` out `req_metadata_width_p`: metadata to LCE.
- `req_metadata_v_o` out 1: metadata valid to LCE.
- `req_complete_i` in 1: LCE transaction done.
- `owner_o` out 1: 0 = I$, 1 = D$; identifies the current or last transaction owner and drives fill steering.
- `busy_o` out 1: a transaction is granted and not yet complete.

## Operation
- FSM states:
  - IDLE: no grant.
  - META: request accepted, awaiting owner metadata.
  - BUSY: metadata sent, awaiting complete.
- Round-robin priority pointer `prio_r`: after a grant to X, `prio_r` points to the other cache. Reset value favors D$.
- IDLE behavior:
  - Select a requester: the only valid one, or `prio_r` if both are valid.
  - `req_v_o` = selected valid; `req_o` = selected payload.
  - Selected `*_req_ready_o` = `req_ready_i`; the non-selected ready is 0.
- Grant lock: if `req_v_o` is high and `req_ready_i` is low, register the selection in `lock_r`. The selection must not change until the handshake, even if the other cache raises valid or `prio_r` favors it.
- Handshake (`req_v_o & req_ready_i`):
  - Register `owner_o`, clear `lock_r`, advance `prio_r`.
  - Go to META. If the owner's `metadata_v` is high in the same cycle, go to BUSY instead.
- Metadata (META, or the handshake cycle):
  - `req_metadata_o` and `req_metadata_v_o` = owner's metadata and valid, passed combinationally.
  - The first owner `metadata_v` moves the FSM META→BUSY.
  - Non-owner metadata is ignored. In IDLE or BUSY, `req_metadata_v_o` = 0.
- Completion:
  - In META or BUSY, `req_complete_i` pulses the owner's `*_complete_o` in the same cycle (combinational) and returns the FSM to IDLE.
  - Complete in META also abandons the pending metadata.
  - `req_complete_i` in IDLE is ignored.
- While not IDLE: `req_v_o` = 0 and both readies = 0.
- `busy_o` = (state != IDLE).

## Timing
- Async reset state:
  - Outputs: `req_v_o`, `req_metadata_v_o`, both readies, both completes, `busy_o` and `owner_o` all read 0 immediately.
  - Registers: FSM = IDLE, `prio_r` = D$, `lock_r` clear.
  - Reset assertion mid-META or mid-BUSY abandons the transaction.
- Request path is zero-latency combinational: valid→`req_v_o` and `req_ready_i`→`*_ready_o`. The only registered elements are FSM, `prio_r`, `lock_r` and `owner_o`.
- Throughput: one transaction in flight. If complete arrives in cycle N, the earliest next handshake is in cycle N+1. Complete and a new handshake never occur in the same cycle.
- `owner_o` updates on the clock edge after the handshake and holds through IDLE until the next handshake, so fills arriving up to complete steer correctly.

## Test plan
1. Reset deasserted; D$ `req_v`=1 at cycle 2, `req_ready_i`=1 → handshake cycle 2, `owner_o`=1 from cycle 3. D$ metadata_v at cycle 3 → `req_metadata_v_o`=1 at cycle 3. `req_complete_i` at cycle 10 → `dcache_req_complete_o`=1 at cycle 10, `icache_req_complete_o`=0, `busy_o`=0 at cycle 11.
2. Both caches valid at cycle 2 after reset → D$ granted first. I$ `ready_o`=0 until D$ completes. I$ handshake occurs the cycle after D$ complete.
3. Both continuously valid for 6 transactions → grant order D,I,D,I,D,I.
4. `req_ready_i`=0 for 4 cycles with I$ selected; D$ raises valid at cycle 2 and has priority → `req_o` stays the I$ payload until I$ handshakes.
5. D$ metadata_v in the handshake cycle → FSM straight to BUSY; I$ metadata_v pulsed during D$ ownership → `req_metadata_v_o` stays 0.
6. `reset_n_i` dropped mid-BUSY (between clock edges) → all outputs 0 immediately. After release, a lone I$ request is granted, and a later `req_complete_i` in IDLE produces no complete pulse.
